// File: rtl/hex_pkg.sv
// Shared types and sizing for the hex memory arbiter: bus widths, memory
// word-address width and the requester port tag.
package hex_pkg;

    localparam int ADDR_WIDTH     = 20;
    localparam int DATA_WIDTH     = 32;
    localparam int MEM_ADDR_WIDTH = 16;
    localparam int MEM_ADDR_MSB   = MEM_ADDR_WIDTH - 1;
    localparam int CONF_WIDTH     = 16;

    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;
    typedef logic [MEM_ADDR_WIDTH-3:0] mem_addr_t;
    typedef logic [CONF_WIDTH-1:0]     conf_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

endpackage

// File: rtl/hex_mem_arbiter_if.sv
// Requester-side bus of the arbiter: instruction-fetch read port and
// data read/write port, each with request handshake and read response.
interface hex_mem_arbiter_if;
    import hex_pkg::*;

    logic  i_if_valid;
    logic  o_if_ready;
    addr_t i_if_addr;
    logic  o_if_rvalid;
    data_t o_if_rdata;

    logic  i_d_valid;
    logic  o_d_ready;
    addr_t i_d_addr;
    logic  i_d_we;
    data_t i_d_wdata;
    logic  o_d_rvalid;
    data_t o_d_rdata;
    logic  o_d_err;

    modport slave (
        input  i_if_valid, i_if_addr,
        output o_if_ready, o_if_rvalid, o_if_rdata,
        input  i_d_valid, i_d_addr, i_d_we, i_d_wdata,
        output o_d_ready, o_d_rvalid, o_d_rdata, o_d_err
    );

    modport master (
        output i_if_valid, i_if_addr,
        input  o_if_ready, o_if_rvalid, o_if_rdata,
        output i_d_valid, i_d_addr, i_d_we, i_d_wdata,
        input  o_d_ready, o_d_rvalid, o_d_rdata, o_d_err
    );

endinterface

// File: rtl/hex_rr_arb2.sv
// Two-input arbiter: combinational ready per requester, round-robin on
// conflict unless FIXED_PRIO hands every conflict to the data port.
module hex_rr_arb2
    import hex_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_if,
    input  logic i_req_d,
    output logic o_rdy_if,
    output logic o_rdy_d
);

    port_t r_last_grant;
    port_t w_last_grant_nxt;
    logic  w_conflict;
    logic  w_if_wins;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        w_conflict       = i_req_if && i_req_d;
        w_if_wins        = FIXED_PRIO ? 1'b0 : (r_last_grant == PORT_D);
        o_rdy_if         = !i_req_d || (w_conflict && w_if_wins);
        o_rdy_d          = !i_req_if || (w_conflict && !w_if_wins);
        w_last_grant_nxt = r_last_grant;
        if (i_req_if && o_rdy_if) begin
            w_last_grant_nxt = PORT_IF;
        end else if (i_req_d && o_rdy_d) begin
            w_last_grant_nxt = PORT_D;
        end
    end

    // Starting at PORT_D lets the fetch port win the first conflict after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_grant <= PORT_D;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

endmodule

// File: rtl/hex_mem_arbiter.sv
// Shares one single-port memory between a fetch port and a data port:
// one transfer per cycle, 1-cycle read latency, misaligned data flagged.
module hex_mem_arbiter
    import hex_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    hex_mem_arbiter_if.slave  io_bus,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output mem_addr_t         o_mem_addr,
    output data_t             o_mem_wdata,
    input  data_t             i_mem_rdata,
    output conf_t             o_conflicts
);

    logic  w_if_rdy;
    logic  w_d_rdy;
    logic  w_xfer_if;
    logic  w_xfer_d;
    logic  w_d_mis;
    logic  w_d_mem_ok;
    logic  w_unused;

    logic  r_rsp_vld;
    port_t r_rsp_port;
    logic  r_d_err;
    conf_t r_conflicts;

    hex_rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req_if (io_bus.i_if_valid),
        .i_req_d  (io_bus.i_d_valid),
        .o_rdy_if (w_if_rdy),
        .o_rdy_d  (w_d_rdy)
    );

    assign w_xfer_if  = io_bus.i_if_valid && w_if_rdy;
    assign w_xfer_d   = io_bus.i_d_valid && w_d_rdy;
    assign w_d_mis    = |io_bus.i_d_addr[1:0];
    assign w_d_mem_ok = w_xfer_d && !w_d_mis;

    assign o_mem_en    = w_xfer_if || w_d_mem_ok;
    assign o_mem_we    = w_d_mem_ok && io_bus.i_d_we;
    assign o_mem_addr  = w_xfer_d ? io_bus.i_d_addr[MEM_ADDR_MSB:2]
                                  : io_bus.i_if_addr[MEM_ADDR_MSB:2];
    assign o_mem_wdata = io_bus.i_d_wdata;

    assign io_bus.o_if_ready = w_if_rdy;
    assign io_bus.o_d_ready  = w_d_rdy;

    // A misaligned data read still owes a response, with zero data.
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_port  <= PORT_IF;
            r_d_err     <= 1'b0;
            r_conflicts <= '0;
        end else begin
            r_rsp_vld  <= w_xfer_if || (w_xfer_d && !io_bus.i_d_we);
            r_rsp_port <= w_xfer_d ? PORT_D : PORT_IF;
            r_d_err    <= w_xfer_d && w_d_mis;
            if (io_bus.i_if_valid && io_bus.i_d_valid && (r_conflicts != '1)) begin
                r_conflicts <= r_conflicts + 1'b1;
            end
        end
    end

    assign io_bus.o_if_rvalid = r_rsp_vld && (r_rsp_port == PORT_IF);
    assign io_bus.o_if_rdata  = i_mem_rdata;
    assign io_bus.o_d_rvalid  = r_rsp_vld && (r_rsp_port == PORT_D);
    assign io_bus.o_d_rdata   = r_d_err ? '0 : i_mem_rdata;
    assign io_bus.o_d_err     = r_d_err;
    assign o_conflicts        = r_conflicts;

    // Fetch byte offset and address bits above the memory window are ignored.
    assign w_unused = ^{io_bus.i_if_addr[1:0],
                        io_bus.i_if_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                        io_bus.i_d_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

endmodule

// File: tb/tb_hex_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of arbitration, memory contents and responses.
module tb_hex_mem_arbiter;
    import hex_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hex_mem_arbiter_if bus0();
    hex_mem_arbiter_if bus1();

    logic      mem0_en, mem0_we, mem1_en, mem1_we;
    mem_addr_t mem0_addr, mem1_addr;
    data_t     mem0_wdata, mem1_wdata;
    data_t     mem0_rdata = '0;
    data_t     mem1_rdata = '0;
    conf_t     conf0, conf1;

    hex_mem_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus0),
        .o_mem_en(mem0_en), .o_mem_we(mem0_we), .o_mem_addr(mem0_addr),
        .o_mem_wdata(mem0_wdata), .i_mem_rdata(mem0_rdata), .o_conflicts(conf0)
    );

    hex_mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(bus1),
        .o_mem_en(mem1_en), .o_mem_we(mem1_we), .o_mem_addr(mem1_addr),
        .o_mem_wdata(mem1_wdata), .i_mem_rdata(mem1_rdata), .o_conflicts(conf1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory as seen by the DUT, and the model's own idea of it.
    data_t env_mem[mem_addr_t];
    data_t ref_mem[mem_addr_t];
    data_t env_next;

    // Model state: last granted port (0 = fetch, 1 = data), expected response, conflicts.
    int    m_last;
    logic  m_rsp_if, m_rsp_d, m_err;
    data_t m_rsp_data;
    int    m_conf;

    function automatic data_t init_word(mem_addr_t w);
        return 32'hC0DE0000 ^ (32'(w) * 32'h9E3779B1);
    endfunction

    function data_t env_rd(mem_addr_t w);
        return env_mem.exists(w) ? env_mem[w] : init_word(w);
    endfunction

    function data_t ref_rd(mem_addr_t w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic idle_inputs();
        bus0.i_if_valid = 1'b0; bus0.i_if_addr = '0; bus0.i_d_valid = 1'b0;
        bus0.i_d_addr = '0; bus0.i_d_we = 1'b0; bus0.i_d_wdata = '0;
        bus1.i_if_valid = 1'b0; bus1.i_if_addr = '0; bus1.i_d_valid = 1'b0;
        bus1.i_d_addr = '0; bus1.i_d_we = 1'b0; bus1.i_d_wdata = '0;
    endtask

    task automatic model_reset();
        m_last = 1; m_rsp_if = 1'b0; m_rsp_d = 1'b0; m_err = 1'b0;
        m_rsp_data = '0; m_conf = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        mem0_rdata = $urandom;
        mem1_rdata = $urandom;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock on dut_rr: drive, compare combinational and registered outputs, advance model.
    task automatic run_cycle(input logic ifv, input addr_t ifa, input logic dv,
                             input addr_t da, input logic dwe, input data_t dwd,
                             output int grant);
        int        win;
        logic      aln, e_rif, e_rd, e_en, e_we;
        mem_addr_t e_ma;
        @(negedge clk);
        bus0.i_if_valid = ifv; bus0.i_if_addr = ifa;
        bus0.i_d_valid = dv; bus0.i_d_addr = da; bus0.i_d_we = dwe; bus0.i_d_wdata = dwd;
        #1;
        if (ifv && dv)  win = (m_last == 1) ? 0 : 1;
        else if (ifv)   win = 0;
        else if (dv)    win = 1;
        else            win = -1;
        aln   = (da[1:0] == 2'b00);
        e_rif = (!ifv && !dv) || (win == 0);
        e_rd  = (!ifv && !dv) || (win == 1);
        e_en  = (win == 0) || (win == 1 && aln);
        e_we  = (win == 1) && aln && dwe;
        e_ma  = (win == 0) ? ifa[MEM_ADDR_MSB:2] : da[MEM_ADDR_MSB:2];

        n_checks++; if (bus0.o_if_ready !== e_rif) begin n_fail++; $display("FAIL if_ready: got %b exp %b", bus0.o_if_ready, e_rif); end
        n_checks++; if (bus0.o_d_ready !== e_rd) begin n_fail++; $display("FAIL d_ready: got %b exp %b", bus0.o_d_ready, e_rd); end
        n_checks++; if (mem0_en !== e_en) begin n_fail++; $display("FAIL mem_en: got %b exp %b", mem0_en, e_en); end
        n_checks++; if (mem0_we !== e_we) begin n_fail++; $display("FAIL mem_we: got %b exp %b", mem0_we, e_we); end
        if (e_en) begin
            n_checks++; if (mem0_addr !== e_ma) begin n_fail++; $display("FAIL mem_addr: got %h exp %h", mem0_addr, e_ma); end
        end
        if (e_we) begin
            n_checks++; if (mem0_wdata !== dwd) begin n_fail++; $display("FAIL mem_wdata: got %h exp %h", mem0_wdata, dwd); end
        end
        n_checks++; if (bus0.o_if_rvalid !== m_rsp_if) begin n_fail++; $display("FAIL if_rvalid: got %b exp %b", bus0.o_if_rvalid, m_rsp_if); end
        n_checks++; if (bus0.o_d_rvalid !== m_rsp_d) begin n_fail++; $display("FAIL d_rvalid: got %b exp %b", bus0.o_d_rvalid, m_rsp_d); end
        n_checks++; if (bus0.o_d_err !== m_err) begin n_fail++; $display("FAIL d_err: got %b exp %b", bus0.o_d_err, m_err); end
        if (m_rsp_if) begin
            n_checks++; if (bus0.o_if_rdata !== m_rsp_data) begin n_fail++; $display("FAIL if_rdata: got %h exp %h", bus0.o_if_rdata, m_rsp_data); end
        end
        if (m_rsp_d) begin
            n_checks++; if (bus0.o_d_rdata !== m_rsp_data) begin n_fail++; $display("FAIL d_rdata: got %h exp %h", bus0.o_d_rdata, m_rsp_data); end
        end
        n_checks++; if (conf0 !== m_conf[CONF_WIDTH-1:0]) begin n_fail++; $display("FAIL conflicts: got %0d exp %0d", conf0, m_conf); end

        if (ifv && bus0.o_if_ready)     grant = 0;
        else if (dv && bus0.o_d_ready)  grant = 1;
        else                            grant = -1;

        if (mem0_en && mem0_we) env_mem[mem0_addr] = mem0_wdata;
        env_next = (mem0_en && !mem0_we) ? env_rd(mem0_addr) : data_t'($urandom);

        m_rsp_if   = (win == 0);
        m_rsp_d    = (win == 1) && !dwe;
        m_err      = (win == 1) && !aln;
        m_rsp_data = (win == 0) ? ref_rd(ifa[MEM_ADDR_MSB:2])
                   : (aln ? ref_rd(da[MEM_ADDR_MSB:2]) : '0);
        if (e_we) ref_mem[da[MEM_ADDR_MSB:2]] = dwd;
        if (win >= 0) m_last = win;
        if (ifv && dv && m_conf < 65535) m_conf++;

        @(posedge clk);
        #1 mem0_rdata = env_next;
    endtask

    task automatic idle_cycle();
        int g;
        run_cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, g);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (bus0.o_if_rvalid !== 1'b0 || bus1.o_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_if_rvalid: got %b/%b exp 0", bus0.o_if_rvalid, bus1.o_if_rvalid); end
        n_checks++; if (bus0.o_d_rvalid !== 1'b0 || bus1.o_d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid: got %b/%b exp 0", bus0.o_d_rvalid, bus1.o_d_rvalid); end
        n_checks++; if (bus0.o_d_err !== 1'b0) begin n_fail++; $display("FAIL reset_d_err: got %b exp 0", bus0.o_d_err); end
        n_checks++; if (conf0 !== '0 || conf1 !== '0) begin n_fail++; $display("FAIL reset_conflicts: got %0d/%0d exp 0", conf0, conf1); end
        n_checks++; if (bus0.o_if_ready !== 1'b1 || bus0.o_d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b%b exp 11", bus0.o_if_ready, bus0.o_d_ready); end
        n_checks++; if (mem0_en !== 1'b0 || mem0_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_idle: got en=%b we=%b exp 0", mem0_en, mem0_we); end
        apply_reset();
    endtask

    task automatic test_fetch_read();
        int g;
        apply_reset();
        env_mem[14'h0004] = 32'hDEADBEEF;
        ref_mem[14'h0004] = 32'hDEADBEEF;
        run_cycle(1'b1, 20'h00010, 1'b0, '0, 1'b0, '0, g);
        #1;
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL fetch_grant: got %0d exp 0", g); end
        n_checks++; if (bus0.o_if_rvalid !== 1'b1 || bus0.o_if_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fetch_rsp: got v=%b d=%h exp v=1 d=deadbeef", bus0.o_if_rvalid, bus0.o_if_rdata); end
        n_checks++; if (bus0.o_d_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_d_quiet: got %b exp 0", bus0.o_d_rvalid); end
        idle_cycle();
    endtask

    task automatic test_conflict_rr();
        int g;
        int exp_g[4] = '{0, 1, 0, 1};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, addr_t'(32'h100 + 4 * i), 1'b1, addr_t'(32'h200 + 4 * i), 1'b0, '0, g);
            n_checks++; if (g !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d exp %0d", i, g, exp_g[i]); end
        end
        idle_cycle();
        n_checks++; if (conf0 !== 16'd4) begin n_fail++; $display("FAIL rr_conflicts: got %0d exp 4", conf0); end
    endtask

    task automatic test_fixed_prio();
        data_t v;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus1.i_if_valid = 1'b1; bus1.i_if_addr = 20'h00100;
            bus1.i_d_valid = 1'b1; bus1.i_d_addr = addr_t'(32'h40 + 4 * i); bus1.i_d_we = 1'b0;
            #1;
            n_checks++; if (bus1.o_if_ready !== 1'b0 || bus1.o_d_ready !== 1'b1) begin n_fail++; $display("FAIL fp_ready[%0d]: got if=%b d=%b exp if=0 d=1", i, bus1.o_if_ready, bus1.o_d_ready); end
            n_checks++; if (mem1_en !== 1'b1 || mem1_we !== 1'b0 || mem1_addr !== mem_addr_t'(16 + i)) begin n_fail++; $display("FAIL fp_mem[%0d]: got en=%b we=%b a=%h exp 1 0 %h", i, mem1_en, mem1_we, mem1_addr, 16 + i); end
            @(posedge clk);
            v = $urandom;
            #1 mem1_rdata = v;
            #1;
            n_checks++; if (bus1.o_d_rvalid !== 1'b1 || bus1.o_d_rdata !== v || bus1.o_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL fp_rsp[%0d]: got dv=%b d=%h iv=%b exp 1 %h 0", i, bus1.o_d_rvalid, bus1.o_d_rdata, bus1.o_if_rvalid, v); end
        end
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++; if (conf1 !== 16'd3) begin n_fail++; $display("FAIL fp_conflicts: got %0d exp 3", conf1); end
    endtask

    task automatic test_write_read();
        int g;
        apply_reset();
        run_cycle(1'b0, '0, 1'b1, 20'h00020, 1'b1, 32'h12345678, g);
        run_cycle(1'b0, '0, 1'b1, 20'h00020, 1'b0, '0, g);
        #1;
        n_checks++; if (bus0.o_d_rvalid !== 1'b1 || bus0.o_d_rdata !== 32'h12345678 || bus0.o_if_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd: got dv=%b d=%h iv=%b exp 1 12345678 0", bus0.o_d_rvalid, bus0.o_d_rdata, bus0.o_if_rvalid); end
        idle_cycle();
    endtask

    task automatic test_misaligned();
        int g;
        apply_reset();
        run_cycle(1'b0, '0, 1'b1, 20'h00003, 1'b0, '0, g);
        #1;
        n_checks++; if (bus0.o_d_err !== 1'b1 || bus0.o_d_rvalid !== 1'b1 || bus0.o_d_rdata !== '0) begin n_fail++; $display("FAIL misaligned_rd: got err=%b v=%b d=%h exp 1 1 0", bus0.o_d_err, bus0.o_d_rvalid, bus0.o_d_rdata); end
        run_cycle(1'b0, '0, 1'b1, 20'h00022, 1'b1, 32'hBAD0BAD0, g);
        run_cycle(1'b0, '0, 1'b1, 20'h00020, 1'b0, '0, g);
        idle_cycle();
    endtask

    task automatic test_random();
        int    g;
        logic  ifv, dv, dwe;
        addr_t ifa, da;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            ifv = ($urandom % 4) != 0;
            dv  = ($urandom % 3) != 0;
            dwe = $urandom % 2;
            ifa = addr_t'($urandom) & 20'hF003F;
            da  = addr_t'($urandom) & 20'hF003C;
            if ($urandom % 5 == 0) da = da | addr_t'($urandom % 4);
            run_cycle(ifv, ifa, dv, da, dwe, data_t'($urandom), g);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_read();
        int g;
        apply_reset();
        run_cycle(1'b1, 20'h00004, 1'b1, 20'h00008, 1'b0, '0, g);
        run_cycle(1'b1, 20'h00010, 1'b0, '0, 1'b0, '0, g);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.o_if_rvalid !== 1'b0 || bus0.o_d_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid: got %b/%b exp 0", bus0.o_if_rvalid, bus0.o_d_rvalid); end
        n_checks++; if (conf0 !== '0) begin n_fail++; $display("FAIL midrst_conflicts: got %0d exp 0", conf0); end
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle_cycle();
    endtask

    task automatic test_saturation();
        apply_reset();
        bus0.i_if_valid = 1'b1; bus0.i_if_addr = 20'h00000;
        bus0.i_d_valid = 1'b1; bus0.i_d_addr = 20'h00004; bus0.i_d_we = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        n_checks++; if (conf0 !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h exp fffe", conf0); end
        @(posedge clk); #1;
        n_checks++; if (conf0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hit: got %h exp ffff", conf0); end
        repeat (3) @(posedge clk); #1;
        n_checks++; if (conf0 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h exp ffff", conf0); end
        apply_reset();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_fetch_read();
        test_conflict_rr();
        test_fixed_prio();
        test_write_read();
        test_misaligned();
        test_random();
        test_reset_mid_read();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
